// File: rtl/sram_mem_controller_if.sv
// MEM-stage request bus between the pipeline and sram_mem_controller.
// master: pipeline side (drives requests); slave: controller side.
interface sram_mem_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en,
    output mem_w_en,
    output address,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  address,
    input  wdata,
    output rdata,
    output ready
  );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage word port on a 16-bit asynchronous SRAM. Each 32-bit request becomes
// two half-word transfers (low half first); ready is held low while busy so the
// pipeline freezes with the request stable.
// Optional build macro: SRAM_WRITE_BUFFER_EN -- posts writes (ready=1 in the
// accepting cycle) and runs the SRAM transfer in the background.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_controller_if.slave bus,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic               we_n_q, we_n_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [SRAM_AW-2:0] word;
  logic               req;
  logic               last;

  // Half-word pair index; out-of-range addresses simply wrap.
  assign word = (SRAM_AW-1)'((bus.address - BASE_ADDR) >> 2);
  assign req  = bus.mem_r_en | bus.mem_w_en;
  assign last = (cnt_q == '0);

  // Next-state: sequence LOW/HIGH phases, latch request, capture read halves.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    wdata_hi_d = wdata_hi_q;
    we_n_d     = we_n_q;
    rdata_d    = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StLow;
          cnt_d      = CntLoad;
          wr_d       = bus.mem_w_en;
          addr_d     = {word, 1'b0};
          dq_out_d   = bus.wdata[15:0];
          wdata_hi_d = bus.wdata[31:16];
          we_n_d     = ~bus.mem_w_en;
        end
      end
      StLow: begin
        if (last) begin
          state_d   = StHigh;
          cnt_d     = CntLoad;
          addr_d[0] = 1'b1;
          dq_out_d  = wdata_hi_q;
          if (!wr_q) rdata_d[15:0] = sram_dq;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHigh: begin
        if (last) begin
          we_n_d  = 1'b1;
          state_d = StDone;
          if (!wr_q) rdata_d[31:16] = sram_dq;
`ifdef SRAM_WRITE_BUFFER_EN
          // A posted write was already acknowledged; no DONE cycle needed.
          if (wr_q) state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered SRAM-side outputs; async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      wdata_hi_q <= '0;
      we_n_q     <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      wdata_hi_q <= wdata_hi_d;
      we_n_q     <= we_n_d;
      rdata_q    <= rdata_d;
    end
  end

  // Freeze the pipeline unless idle with nothing asked, or finishing.
  always_comb begin
    bus.ready = ((state_q == StIdle) && !req) || (state_q == StDone);
`ifdef SRAM_WRITE_BUFFER_EN
    if ((state_q == StIdle) && bus.mem_w_en) bus.ready = 1'b1;
`endif
  end

  // The bus is driven exactly while write-enable is asserted, so the SRAM
  // (output-enabled whenever not writing) never fights the controller.
  assign sram_dq   = (!we_n_q) ? dq_out_q : 16'bz;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign bus.rdata = rdata_q;

  assign sram_oe_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit async SRAM.
module tb_sram_mem_controller;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  sram_mem_controller_if bus ();

  sram_mem_controller #(
    .BASE_ADDR  (32'd1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (18)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sram_dq  (sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  // SRAM model: reads combinationally while not writing, writes on clock edges.
  logic [15:0] mem [0:(1<<18)-1];
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'bz;
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SRAM_WRITE_BUFFER_EN
  localparam int WrLat     = 0;
  localparam int WrAfterWr = 4;
  localparam int RdAfterWr = 9;
`else
  localparam int WrLat     = 5;
  localparam int WrAfterWr = 5;
  localparam int RdAfterWr = 5;
`endif
  localparam int RdLat = 5;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   age    = 0;
  bit   busy   = 1'b0;
  bit   done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one request (called right after a posedge) and hold it until the
  // monitor has seen ready.
  task automatic op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                    input logic [31:0] exp_rd, input int lat, input string name);
    exp_t e;
    bit   ok;
    #1;
    bus.mem_w_en = wr;
    bus.mem_r_en = !wr;
    bus.address  = addr;
    bus.wdata    = data;
    e.rd   = !wr;
    e.data = exp_rd;
    e.lat  = lat;
    e.name = name;
    exp_q.push_back(e);
    age  = 0;
    done = 1'b0;
    busy = 1'b1;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready stayed 0, want 1 within 64 cycles", name);
      busy = 1'b0;
      exp_q.delete();
    end
    done = 1'b0;
  endtask

  task automatic idle(input int n);
    #1;
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: on each falling edge, pop and compare when the DUT reports ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: ready with empty queue (got 1, want 0)");
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_lat"}, 32'(age), 32'(e.lat));
            if (e.rd) chk({e.name, "_rdata"}, bus.rdata, e.data);
          end
          busy = 1'b0;
          done = 1'b1;
        end else begin
          age++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.wdata    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // 1: reset state
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("tied_low", 32'({sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 32'h0);
    @(posedge clk);

    // 2: first write, then let any background transfer drain
    op(1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, WrLat, "wr1024");
    idle(8);
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);

    // 3: read it back
    op(1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, RdLat, "rd1024");

    // 4: back-to-back writes then reads
    op(1'b1, 32'd1028, 32'hA5A51234, 32'h0, WrLat, "wr1028");
    op(1'b1, 32'd1032, 32'h0F0FF0F0, 32'h0, WrAfterWr, "wr1032");
    op(1'b0, 32'd1028, 32'h0, 32'hA5A51234, RdAfterWr, "rd1028");
    op(1'b0, 32'd1032, 32'h0, 32'h0F0FF0F0, RdLat, "rd1032");
    chk("mem2", 32'(mem[2]), 32'h00001234);
    chk("mem5", 32'(mem[5]), 32'h00000F0F);

    // 5: reset during the HIGH phase of a write to 1036
    #1;
    bus.mem_w_en = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.address  = 32'd1036;
    bus.wdata    = 32'hCAFE5678;
    @(posedge clk);
    #1 bus.mem_w_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_addr", 32'(sram_addr), 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("mem6_partial", 32'(mem[6]), 32'h00005678);
    @(posedge clk);
    op(1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, RdLat, "rd1024_post_rst");

    // Address wrap: word index truncates to 17 bits, aliasing onto word 0
    op(1'b1, 32'd1024 + 32'h0008_0000, 32'h11112222, 32'h0, WrLat, "wr_alias");
    op(1'b0, 32'd1024, 32'h0, 32'h11112222, RdAfterWr, "rd_alias");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
